// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D main-memory arbiter.
// Holds the arbiter state encoding and the default geometry parameters.
// Imported by the arbiter top and its beat sequencer.
package mem_arb_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I_RD = 2'd1,
    ARB_D_RD = 2'd2,
    ARB_D_WR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_beat.sv
// Beat counter and line-aligned word address generator for refills.
// Latency: address is combinational from the registered beat index.
// Backpressure: counter only moves on i_advance, so mem_ready stalls hold the beat.
module mem_arb_beat
  import mem_arb_pkg::*;
#(
  parameter int  LINE_WORDS = LINE_WORDS_DEF,
  parameter int  AW         = AW_DEF,
  localparam int BW         = $clog2(LINE_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_base_addr,
  input  logic          i_advance,
  input  logic          i_clear,
  output logic [BW-1:0] o_beat_idx,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [BW-1:0] LAST_IDX  = BW'(LINE_WORDS - 1);

  logic [BW-1:0] r_beat;

  // Beat index: restarts at 0 when idle, steps on each completed beat and wraps after the last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_beat <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_advance) begin
      r_beat <= r_beat + {{(BW-1){1'b0}}, 1'b1};
    end
  end

  // Low address bits of the request are replaced by the beat index; upper bits never carry.
  assign o_addr     = (i_base_addr & ~LINE_MASK) | AW'(r_beat);
  assign o_beat_idx = r_beat;
  assign o_last     = (r_beat == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/refill sequencer sharing one memory port between I-cache and D-cache (D has priority).
// Latency: grant one cycle after req; reads take LINE_WORDS beats, writes one beat, IDLE gap between.
// Backpressure: each beat holds mem_en/address until mem_ready; no preemption of a granted transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  LINE_WORDS = LINE_WORDS_DEF,
  parameter int  AW         = AW_DEF,
  parameter int  DW         = DW_DEF,
  localparam int BW         = $clog2(LINE_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          state,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          d_done,
  output logic [BW-1:0] beat_idx,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  arb_state_t    r_fsm;
  arb_state_t    w_fsm_nxt;
  logic [AW-1:0] w_base_addr;
  logic [AW-1:0] w_line_addr;
  logic          w_last;
  logic          w_advance;
  logic          w_clear;
  logic          w_is_read;

  assign w_is_read   = (r_fsm == ARB_I_RD) || (r_fsm == ARB_D_RD);
  assign w_advance   = w_is_read && mem_ready;
  assign w_clear     = (r_fsm == ARB_IDLE);
  assign w_base_addr = (r_fsm == ARB_I_RD) ? i_addr : d_addr;

  mem_arb_beat #(
    .LINE_WORDS (LINE_WORDS),
    .AW         (AW)
  ) u_beat (
    .clock       (clock),
    .reset       (reset),
    .i_base_addr (w_base_addr),
    .i_advance   (w_advance),
    .i_clear     (w_clear),
    .o_beat_idx  (beat_idx),
    .o_addr      (w_line_addr),
    .o_last      (w_last)
  );

  // State register: reset returns to IDLE even mid-beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm <= ARB_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next state: grants only from IDLE in exec, D before I; transactions always run to done.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ARB_IDLE: begin
        if (state && d_req) begin
          w_fsm_nxt = d_we ? ARB_D_WR : ARB_D_RD;
        end else if (state && i_req) begin
          w_fsm_nxt = ARB_I_RD;
        end
      end
      ARB_I_RD, ARB_D_RD: begin
        if (mem_ready && w_last) begin
          w_fsm_nxt = ARB_IDLE;
        end
      end
      ARB_D_WR: begin
        if (mem_ready) begin
          w_fsm_nxt = ARB_IDLE;
        end
      end
      default: w_fsm_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: memory side decoded from state/counter; completion and read data follow mem_ready.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rdata   = '0;
    d_rvalid  = 1'b0;
    d_done    = 1'b0;
    case (r_fsm)
      ARB_I_RD: begin
        mem_en   = 1'b1;
        busy     = 1'b1;
        mem_addr = w_line_addr;
        i_rdata  = mem_rdata;
        i_rvalid = mem_ready;
        i_done   = mem_ready && w_last;
      end
      ARB_D_RD: begin
        mem_en   = 1'b1;
        busy     = 1'b1;
        mem_addr = w_line_addr;
        d_rdata  = mem_rdata;
        d_rvalid = mem_ready;
        d_done   = mem_ready && w_last;
      end
      ARB_D_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        busy      = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = mem_ready;
      end
      default: ;
    endcase
  end

endmodule
